uart_buffered_loopback: RTL and testbench
=========================================

UART_BUFFERED_LOOPBACK -- requirements
Module: uart_buffered_loopback

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 10417, giving Clk cycles per UART bit (100 MHz, 9600 baud); minimum value 4.
REQ-002 SHALL provide parameter DATA_BITS, default 8, giving data bits per frame (5..9), sent and received LSB first.
REQ-003 SHALL provide parameter DEPTH, default 16, giving buffer entries; the value must be a power of two, at least 2.
REQ-004 SHALL provide parameter MODE, default 0: 0 = stream (echo each byte as soon as it is buffered), 1 = batch (hold until buffer full, then drain all).
REQ-005 Clk  input  1  single system clock; all logic is on its rising edge.
REQ-006 Rst_n  input  1  reset, synchronous to Clk, active-low.
REQ-007 En  input  1  enable; low stops new reception and new transmission starts.
REQ-008 Rx  input  1  asynchronous serial input, idle high.
REQ-009 Tx  output  1  serial output, idle high.
REQ-010 TxDone  output  1  one-cycle pulse at the end of each transmitted stop bit.
REQ-011 RxByte  output  DATA_BITS  last byte received without error.
REQ-012 Count  output  $clog2(DEPTH)+1  number of bytes currently buffered.
REQ-013 Overrun  output  1  sticky flag; a byte was dropped because the buffer was full.
REQ-014 FrameErr  output  1  sticky flag; a stop bit was sampled low (or parity failed, see REQ-031).

Function
REQ-015 Rx SHALL pass through a two-flop synchroniser before any use; the synchroniser adds 2 cycles of input latency.
REQ-016 The receiver FSM SHALL use states IDLE, START, DATA, STOP, and SHALL leave IDLE on a synchronised falling edge only when En=1.
REQ-017 In START, the receiver SHALL resample at CLKS_PER_BIT/2; if Rx is high it SHALL return to IDLE (glitch reject), otherwise go to DATA.
REQ-018 The receiver SHALL sample each data bit and the stop bit at multiples of CLKS_PER_BIT after the mid-start sample point.
REQ-019 If the stop bit is sampled high, the receiver SHALL update RxByte and write the byte to the buffer in that same cycle.
REQ-020 If the stop bit is sampled low, the receiver SHALL discard the byte, set FrameErr, and wait in STOP until Rx is high before returning to IDLE.
REQ-021 The buffer SHALL be circular; read and write pointers SHALL wrap from DEPTH-1 to 0.
REQ-022 A write when Count==DEPTH SHALL drop the byte, set Overrun, and leave the buffer contents and Count unchanged.
REQ-023 On a simultaneous write and read in one cycle, both SHALL occur and Count SHALL remain unchanged.
REQ-024 The transmitter FSM SHALL use states IDLE, START, DATA, STOP; each bit SHALL last exactly CLKS_PER_BIT cycles.
REQ-025 In MODE 0, the transmitter SHALL start whenever it is IDLE with Count>0 and En=1; the start bit SHALL begin no more than 3 cycles after the buffer write.
REQ-026 In MODE 1, the transmitter SHALL begin draining when Count reaches DEPTH and SHALL continue until Count==0; bytes received during the drain SHALL be buffered normally.
REQ-027 When En goes low, the transmitter SHALL complete the frame in progress and then not start another; the receiver SHALL complete the frame in progress; buffered data SHALL be retained.
REQ-028 Bytes SHALL be transmitted in reception order, with no duplication and no loss other than per REQ-020 and REQ-022.

Reset
REQ-029 While Rst_n=0 at a Clk edge, both FSMs SHALL go to IDLE, pointers and Count SHALL be 0, and the outputs SHALL be Tx=1, TxDone=0, RxByte=0, Overrun=0, FrameErr=0; buffer RAM contents need not be cleared.
REQ-030 A reset asserted mid-frame SHALL abort that frame immediately: Tx SHALL be high on the next cycle, and no partial byte SHALL be written to the buffer.

Configuration
REQ-031 With macro UART_PARITY_EN defined, both FSMs SHALL add a PARITY state between DATA and STOP carrying an even-parity bit; a received parity mismatch SHALL discard the byte and set FrameErr.
REQ-032 Without UART_PARITY_EN, the frame SHALL be start + DATA_BITS + one stop bit, with no parity logic present.

Verification (CLKS_PER_BIT=16, DEPTH=4, DATA_BITS=8 unless stated)
REQ-033 MODE 0: send 0x61 -> RxByte=0x61, then Tx frame 0x61 starts ≤3 cycles after the write; one TxDone pulse; Count returns to 0.
REQ-034 MODE 1: send 0x61..0x64 -> no Tx activity until Count=4, then frames 0x61,0x62,0x63,0x64 in order with 4 TxDone pulses.
REQ-035 MODE 1: send 5 bytes 0x61..0x65 back-to-back with En=0 on the transmit side via a held-off drain -> 0x65 dropped, Overrun=1, Count=4.
REQ-036 Send 0x62 with a low stop bit -> FrameErr=1, RxByte unchanged, Count unchanged; a following 0x63 is received correctly.
REQ-037 Apply a 0.25-bit low glitch on Rx -> no byte received; assert Rst_n=0 mid-Tx frame -> Tx=1 next cycle, all flags and Count=0.
REQ-038 With UART_PARITY_EN: send 0x61 with correct parity -> echoed with parity bit 1; send with wrong parity -> FrameErr=1 and no echo.

Source files
------------

// File: rtl/uart_buffered_loopback.sv
// -----------------------------------------------------------------------------
// uart_buffered_loopback
//
// UART receiver -> circular byte buffer -> UART transmitter.
//   MODE 0 (stream): each buffered byte is echoed as soon as possible.
//   MODE 1 (batch) : bytes are held until the buffer is full, then the whole
//                    buffer is drained; bytes arriving during the drain are
//                    buffered normally.
//
// Optional feature: define UART_PARITY_EN to add an even-parity bit between
// the data bits and the stop bit in both directions. A received parity
// mismatch discards the byte and sets FrameErr.
//
// Parameters
//   CLKS_PER_BIT  Clk cycles per UART bit (>= 4)
//   DATA_BITS     data bits per frame, LSB first (5..9)
//   DEPTH         buffer entries (power of two, >= 2)
//   MODE          0 = stream, 1 = batch
//
// Ports
//   Clk       system clock, rising edge
//   Rst_n     synchronous active-low reset
//   En        low: no new receive frame or transmit frame is started
//   Rx        asynchronous serial input, idle high
//   Tx        serial output, idle high
//   TxDone    one-cycle pulse after each transmitted stop bit
//   RxByte    last byte received without error
//   Count     bytes currently buffered (the byte being sent stays counted
//             until its stop bit completes)
//   Overrun   sticky: a received byte was dropped because the buffer was full
//   FrameErr  sticky: bad stop bit (or bad parity)
// -----------------------------------------------------------------------------
module uart_buffered_loopback #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int DATA_BITS    = 8,
  parameter int DEPTH        = 16,
  parameter int MODE         = 0
) (
  input  logic                       Clk,
  input  logic                       Rst_n,
  input  logic                       En,
  input  logic                       Rx,
  output logic                       Tx,
  output logic                       TxDone,
  output logic [DATA_BITS-1:0]       RxByte,
  output logic [$clog2(DEPTH):0]     Count,
  output logic                       Overrun,
  output logic                       FrameErr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  // ---------------------------------------------------------------------------
  // Rx synchroniser and falling-edge detect
  // ---------------------------------------------------------------------------
  logic rx_meta, rx_sync, rx_sync_d;
  logic rx_fall;

  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge value of the others; = here would collapse the two-flop chain.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      rx_sync_d <= 1'b1;
    end else begin
      rx_meta   <= Rx;
      rx_sync   <= rx_meta;
      rx_sync_d <= rx_sync;
    end
  end

  assign rx_fall = rx_sync_d & ~rx_sync;

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  state_t               rx_state;
  logic [CW-1:0]        rx_cnt;
  logic [BW-1:0]        rx_bit;
  logic [DATA_BITS-1:0] rx_shreg;
  logic                 rx_wait_high;  // bad stop seen, waiting for line idle
  logic                 rx_tick;
  logic                 rx_stop_ok;    // good frame completes this cycle
`ifdef UART_PARITY_EN
  logic                 rx_par_err;
`endif

  assign rx_tick    = (rx_cnt == BIT_END);
  assign rx_stop_ok = (rx_state == STOP) && rx_tick && rx_sync && !rx_wait_high
`ifdef UART_PARITY_EN
                      && !rx_par_err
`endif
                      ;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      rx_state     <= IDLE;
      rx_cnt       <= '0;
      rx_bit       <= '0;
      rx_shreg     <= '0;
      rx_wait_high <= 1'b0;
      RxByte       <= '0;
      FrameErr     <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_err   <= 1'b0;
`endif
    end else begin
      case (rx_state)
        IDLE: begin
          rx_cnt <= '0;
          if (En && rx_fall) rx_state <= START;
        end
        START: begin
          // Mid-start resample: a line already high again was a glitch.
          if (rx_cnt == HALF_END) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_sync ? IDLE : DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        DATA: begin
          if (rx_tick) begin
            rx_cnt   <= '0;
            rx_shreg <= {rx_sync, rx_shreg[DATA_BITS-1:1]};
            if (rx_bit == LAST_BIT) begin
              rx_wait_high <= 1'b0;
`ifdef UART_PARITY_EN
              rx_state     <= PARITY;
`else
              rx_state     <= STOP;
`endif
            end else begin
              rx_bit <= rx_bit + 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
`ifdef UART_PARITY_EN
        PARITY: begin
          if (rx_tick) begin
            rx_cnt     <= '0;
            // Even parity: data plus parity bit must hold an even number of ones.
            rx_par_err <= ^{rx_shreg, rx_sync};
            rx_state   <= STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (rx_wait_high) begin
            if (rx_sync) begin
              rx_wait_high <= 1'b0;
              rx_state     <= IDLE;
            end
          end else if (rx_tick) begin
            rx_cnt <= '0;
            if (!rx_sync) begin
              FrameErr     <= 1'b1;
              rx_wait_high <= 1'b1;
`ifdef UART_PARITY_EN
            end else if (rx_par_err) begin
              FrameErr <= 1'b1;
              rx_state <= IDLE;
`endif
            end else begin
              RxByte   <= rx_shreg;
              rx_state <= IDLE;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Circular buffer
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic                 full, wr_en, rd_en;
  logic                 tx_done_now;

  assign full  = (Count == FULL_CNT);
  assign wr_en = rx_stop_ok && !full;
  // The entry is released only when its frame has fully left the line.
  assign rd_en = tx_done_now;

  // NOTE: the RAM array has no reset; pointers and Count define which entries
  // are valid, and a resettable array would not map onto RAM primitives.
  always_ff @(posedge Clk) begin
    if (wr_en) mem[wr_ptr] <= rx_shreg;
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      Count   <= '0;
      Overrun <= 1'b0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      if (rx_stop_ok && full) Overrun <= 1'b1;
      case ({wr_en, rd_en})
        2'b10:   Count <= Count + 1'b1;
        2'b01:   Count <= Count - 1'b1;
        default: Count <= Count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  state_t               tx_state;
  logic [CW-1:0]        tx_cnt;
  logic [BW-1:0]        tx_bit;
  logic [DATA_BITS-1:0] tx_shreg;
  logic                 tx_tick;
  logic                 tx_go;
  logic                 draining;      // batch mode: drain in progress
`ifdef UART_PARITY_EN
  logic                 tx_par;
`endif

  assign tx_tick     = (tx_cnt == BIT_END);
  assign tx_done_now = (tx_state == STOP) && tx_tick;
  // full is included directly so a batch drain starts the cycle after the
  // buffer fills rather than waiting for draining to register.
  assign tx_go = (tx_state == IDLE) && En && (Count != '0) &&
                 ((MODE == 0) || draining || full);

  always_ff @(posedge Clk) begin
    if (!Rst_n)              draining <= 1'b0;
    else if (full)           draining <= 1'b1;
    else if (Count == '0)    draining <= 1'b0;
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shreg <= '0;
      Tx       <= 1'b1;
      TxDone   <= 1'b0;
`ifdef UART_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else begin
      TxDone <= 1'b0;
      case (tx_state)
        IDLE: begin
          Tx     <= 1'b1;
          tx_cnt <= '0;
          if (tx_go) begin
            tx_shreg <= mem[rd_ptr];
`ifdef UART_PARITY_EN
            tx_par   <= ^mem[rd_ptr];
`endif
            Tx       <= 1'b0;
            tx_state <= START;
          end
        end
        START: begin
          if (tx_tick) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            Tx       <= tx_shreg[0];
            tx_state <= DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        DATA: begin
          if (tx_tick) begin
            tx_cnt <= '0;
            if (tx_bit == LAST_BIT) begin
`ifdef UART_PARITY_EN
              Tx       <= tx_par;
              tx_state <= PARITY;
`else
              Tx       <= 1'b1;
              tx_state <= STOP;
`endif
            end else begin
              // Shift so tx_shreg[0] always mirrors the bit on the line.
              tx_bit   <= tx_bit + 1'b1;
              Tx       <= tx_shreg[1];
              tx_shreg <= tx_shreg >> 1;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
`ifdef UART_PARITY_EN
        PARITY: begin
          if (tx_tick) begin
            tx_cnt   <= '0;
            Tx       <= 1'b1;
            tx_state <= STOP;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (tx_tick) begin
            tx_cnt   <= '0;
            TxDone   <= 1'b1;
            tx_state <= IDLE;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_buffered_loopback.sv
`timescale 1ns/1ps
// Scoreboard bench: two instances (MODE 0 on dut0, MODE 1 on dut1) with
// CLKS_PER_BIT=16, DEPTH=4, DATA_BITS=8. Stimulus pushes expected echoes into
// per-instance queues; serial monitors decode Tx and compare against them.
module tb_uart_buffered_loopback;

  localparam int CPB   = 16;
  localparam int DB    = 8;
  localparam int DEPTH = 4;
`ifdef UART_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, en0, en1, rx0, rx1;
  logic       tx0, tx1, txdone0, txdone1, ovr0, ovr1, ferr0, ferr1;
  logic [7:0] rxb0, rxb1;
  logic [2:0] cnt0, cnt1;

  uart_buffered_loopback #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .DEPTH(DEPTH), .MODE(0)) dut0 (
    .Clk(clk), .Rst_n(rst_n), .En(en0), .Rx(rx0), .Tx(tx0), .TxDone(txdone0),
    .RxByte(rxb0), .Count(cnt0), .Overrun(ovr0), .FrameErr(ferr0)
  );

  uart_buffered_loopback #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .DEPTH(DEPTH), .MODE(1)) dut1 (
    .Clk(clk), .Rst_n(rst_n), .En(en1), .Rx(rx1), .Tx(tx1), .TxDone(txdone1),
    .RxByte(rxb1), .Count(cnt1), .Overrun(ovr1), .FrameErr(ferr1)
  );

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp0[$];
  logic [7:0] exp1[$];
  bit         ign0 = 1'b0;

  // Background observers (single writer each).
  int   done0 = 0, done1 = 0, tx1_low_cnt = 0, cnt1_at_ovr = -1;
  logic ovr1_q = 1'b0;
  always @(negedge clk) begin
    if (txdone0 === 1'b1) done0++;
    if (txdone1 === 1'b1) done1++;
    if (tx1 === 1'b0) tx1_low_cnt++;
    if (ovr1 === 1'b1 && ovr1_q !== 1'b1) cnt1_at_ovr = int'(cnt1);
    ovr1_q = ovr1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic get_tx(input int w);
    return (w == 0) ? tx0 : tx1;
  endfunction

  task automatic set_rx(input int w, input logic v);
    if (w == 0) rx0 = v;
    else        rx1 = v;
  endtask

  task automatic hold_bit(input int w, input logic v);
    set_rx(w, v);
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send(input int w, input logic [7:0] d, input logic stop_bit);
    hold_bit(w, 1'b0);
    for (int i = 0; i < DB; i++) hold_bit(w, d[i]);
`ifdef UART_PARITY_EN
    hold_bit(w, ^d);
`endif
    hold_bit(w, stop_bit);
    set_rx(w, 1'b1);
  endtask

`ifdef UART_PARITY_EN
  task automatic send_bad_parity(input int w, input logic [7:0] d);
    hold_bit(w, 1'b0);
    for (int i = 0; i < DB; i++) hold_bit(w, d[i]);
    hold_bit(w, ~(^d));
    hold_bit(w, 1'b1);
  endtask
`endif

  task automatic monitor(input int w);
    logic [7:0] d;
    logic [7:0] e;
    logic       stop_b;
`ifdef UART_PARITY_EN
    logic       par_b;
`endif
    forever begin
      @(negedge clk);
      if (get_tx(w) === 1'b0) begin
        repeat (CPB/2) @(negedge clk);
        for (int i = 0; i < DB; i++) begin
          repeat (CPB) @(negedge clk);
          d[i] = get_tx(w);
        end
`ifdef UART_PARITY_EN
        repeat (CPB) @(negedge clk);
        par_b = get_tx(w);
`endif
        repeat (CPB) @(negedge clk);
        stop_b = get_tx(w);
        if (!(w == 0 && ign0)) begin
          if (((w == 0) ? exp0.size() : exp1.size()) == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_frame_dut%0d: got 0x%02h, expected no frame", w, d);
          end else begin
            e = (w == 0) ? exp0.pop_front() : exp1.pop_front();
            check($sformatf("frame_dut%0d", w), d, e);
            check($sformatf("stop_bit_dut%0d", w), stop_b, 1'b1);
`ifdef UART_PARITY_EN
            check($sformatf("parity_bit_dut%0d", w), par_b, ^e);
`endif
          end
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  task automatic wait_empty(input int w, input int budget, input string name);
    int n = 0;
    while (((w == 0) ? exp0.size() : exp1.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, (w == 0) ? exp0.size() : exp1.size(), 0);
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted");
    $fatal(1, "watchdog");
  end

  localparam int FRAME_CYC = FRAME_BITS * CPB;

  initial begin
    int k;
    int d0_before, d1_before, low_before;

    rst_n = 1'b0; en0 = 1'b1; en1 = 1'b1; rx0 = 1'b1; rx1 = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_tx0", tx0, 1'b1);
    check("rst_txdone0", txdone0, 1'b0);
    check("rst_rxbyte0", rxb0, 8'h00);
    check("rst_count0", cnt0, 3'd0);
    check("rst_overrun0", ovr0, 1'b0);
    check("rst_frameerr0", ferr0, 1'b0);
    check("rst_tx1", tx1, 1'b1);
    check("rst_count1", cnt1, 3'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Stream mode echo of 0x61 with start-latency bound
    d0_before = done0;
    exp0.push_back(8'h61);
    fork
      send(0, 8'h61, 1'b1);
      begin
        k = 0;
        while (rxb0 !== 8'h61 && k < 2 * FRAME_CYC) begin @(negedge clk); k++; end
        check("rxbyte_0x61", rxb0, 8'h61);
        k = 0;
        while (tx0 !== 1'b0 && k < 10) begin @(negedge clk); k++; end
        checks++;
        if (k > 3) begin
          failures++;
          $display("FAIL tx_start_latency: %0d cycles after write, required <= 3", k);
        end
      end
    join
    wait_empty(0, 2 * FRAME_CYC, "echo_0x61_seen");
    repeat (2 * CPB) @(negedge clk);
    check("txdone_pulses_0x61", done0 - d0_before, 1);
    check("count0_back_to_0", cnt0, 3'd0);

    // Batch mode: nothing sent until the buffer is full, then ordered drain
    d1_before  = done1;
    low_before = tx1_low_cnt;
    for (int i = 0; i < 4; i++) exp1.push_back(8'h61 + 8'(i));
    for (int i = 0; i < 3; i++) send(1, 8'h61 + 8'(i), 1'b1);
    repeat (CPB) @(negedge clk);
    check("mode1_tx_idle_before_full", tx1_low_cnt - low_before, 0);
    check("mode1_count_3", cnt1, 3'd3);
    send(1, 8'h64, 1'b1);
    wait_empty(1, 6 * FRAME_CYC, "mode1_drain_4_frames");
    repeat (2 * CPB) @(negedge clk);
    check("mode1_txdone_pulses", done1 - d1_before, 4);
    check("mode1_count_0", cnt1, 3'd0);

    // Batch mode overrun: 5 back-to-back bytes, the 5th finds the buffer full
    check("overrun1_clear_before", ovr1, 1'b0);
    for (int i = 0; i < 4; i++) exp1.push_back(8'h61 + 8'(i));
    for (int i = 0; i < 5; i++) send(1, 8'h61 + 8'(i), 1'b1);
    repeat (4) @(negedge clk);
    check("overrun1_set", ovr1, 1'b1);
    check("count1_at_overrun", cnt1_at_ovr, 4);
    wait_empty(1, 6 * FRAME_CYC, "overrun_drain_4_frames");
    repeat (FRAME_CYC + 2 * CPB) @(negedge clk);
    check("overrun_count1_0", cnt1, 3'd0);

    // Low stop bit: byte discarded, then a good byte
    send(0, 8'h62, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    check("frameerr0_set", ferr0, 1'b1);
    check("rxbyte0_unchanged", rxb0, 8'h61);
    check("count0_unchanged", cnt0, 3'd0);
    exp0.push_back(8'h63);
    send(0, 8'h63, 1'b1);
    check("rxbyte_0x63", rxb0, 8'h63);
    wait_empty(0, 2 * FRAME_CYC, "echo_0x63_seen");
    repeat (2 * CPB) @(negedge clk);

    // Quarter-bit glitch is rejected
    d0_before = done0;
    rx0 = 1'b0;
    repeat (CPB/4) @(negedge clk);
    rx0 = 1'b1;
    repeat (FRAME_CYC) @(negedge clk);
    check("glitch_rxbyte0", rxb0, 8'h63);
    check("glitch_count0", cnt0, 3'd0);
    check("glitch_no_txdone", done0 - d0_before, 0);

    // Reset in the middle of a transmitted frame
    ign0 = 1'b1;
    send(0, 8'h64, 1'b1);
    repeat (3 * CPB) @(negedge clk);
    check("rxbyte_0x64", rxb0, 8'h64);
    check("count0_busy_before_reset", cnt0, 3'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_tx0_high", tx0, 1'b1);
    check("midrst_count0", cnt0, 3'd0);
    check("midrst_frameerr0", ferr0, 1'b0);
    check("midrst_rxbyte0", rxb0, 8'h00);
    check("midrst_overrun1", ovr1, 1'b0);
    check("midrst_txdone0", txdone0, 1'b0);
    rst_n = 1'b1;
    repeat (FRAME_CYC + 2 * CPB) @(negedge clk);
    ign0 = 1'b0;
    check("post_rst_tx0_idle", tx0, 1'b1);

`ifdef UART_PARITY_EN
    // Even parity: 0x61 has three ones, so its parity bit is 1
    exp0.push_back(8'h61);
    send(0, 8'h61, 1'b1);
    wait_empty(0, 2 * FRAME_CYC, "parity_echo_0x61");
    repeat (2 * CPB) @(negedge clk);
    send_bad_parity(0, 8'h62);
    repeat (2 * CPB) @(negedge clk);
    check("parity_frameerr0", ferr0, 1'b1);
    check("parity_rxbyte0_kept", rxb0, 8'h61);
    check("parity_count0", cnt0, 3'd0);
    repeat (FRAME_CYC) @(negedge clk);
`endif

    wait_empty(0, 2 * FRAME_CYC, "final_queue0_empty");
    wait_empty(1, 2 * FRAME_CYC, "final_queue1_empty");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
